// File: rtl/core_biu.sv
// -----------------------------------------------------------------------------
// core_biu -- bus interface unit arbitrating an instruction-fetch port and a
// data port onto a single memory bus with at most one outstanding transaction.
//
// Ports
//   clk, rst                     clock (rising edge) and synchronous active-high reset
//   i_req, i_addr                instruction-fetch request and address
//   i_rdata, i_ack               fetch data and one-cycle completion pulse
//   d_req, d_addr,               data request, address,
//   d_wmask, d_wdata             byte strobes (all-zero = read) and store data
//   d_rdata, d_ack               load data and one-cycle completion pulse
//   bus_valid, bus_addr,         memory request, held stable while BUSY
//   bus_wmask, bus_wdata
//   bus_ready, bus_rdata         memory completion and read data (handshake cycle)
//   err_pulse, err_flag          timeout abort pulse and sticky timeout flag
//
// Flow: IDLE -> (grant) -> BUSY -> (bus_ready or timeout) -> RESP -> IDLE.
// Arbitration is round-robin on conflict; the data port wins the first
// conflict after reset. All outputs come straight from registers.
// -----------------------------------------------------------------------------
module core_biu #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic [DATA_W-1:0]     i_rdata,
    output logic                  i_ack,

    input  logic                  d_req,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W/8-1:0]   d_wmask,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_ack,

    output logic                  bus_valid,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W/8-1:0]   bus_wmask,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_ready,
    input  logic [DATA_W-1:0]     bus_rdata,

    output logic                  err_pulse,
    output logic                  err_flag
);

    localparam int STRB_W = DATA_W / 8;

    // Wait counter just wide enough to hold TIMEOUT; one bit when disabled.
    localparam int              CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam bit               TIMEOUT_EN = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e              state_q;
    logic                last_data_q;   // 1: data port was granted most recently
    logic                gnt_data_q;    // 1: current transaction belongs to data port
    logic [CNT_W-1:0]    wait_q;
    logic [CNT_W-1:0]    wait_d;

    logic                bus_valid_q;
    logic [ADDR_W-1:0]   bus_addr_q;
    logic [STRB_W-1:0]   bus_wmask_q;
    logic [DATA_W-1:0]   bus_wdata_q;

    logic [DATA_W-1:0]   i_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;
    logic                i_ack_q;
    logic                d_ack_q;
    logic                err_pulse_q;
    logic                err_flag_q;

    logic                grant_data_s;
    logic                abort_s;

    // Arbitration choice, saturating wait-count increment and timeout detect.
    always_comb begin
        grant_data_s = 1'b0;
        wait_d       = wait_q;
        abort_s      = 1'b0;

        // On conflict the port not granted last wins; otherwise whoever asks.
        if (i_req && d_req) begin
            grant_data_s = ~last_data_q;
        end else if (d_req) begin
            grant_data_s = 1'b1;
        end else begin
            grant_data_s = 1'b0;
        end

        if (wait_q == CNT_MAX) begin
            wait_d = wait_q;
        end else begin
            wait_d = wait_q + CNT_ONE;
        end

        // Abort when this waiting cycle brings the count to TIMEOUT; a
        // bus_ready in that same cycle still wins as a normal completion.
        if (TIMEOUT_EN && !bus_ready && (wait_d == CNT_LIMIT)) begin
            abort_s = 1'b1;
        end else begin
            abort_s = 1'b0;
        end
    end

    // Transaction FSM with all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_data_q <= 1'b0;
            gnt_data_q  <= 1'b0;
            wait_q      <= '0;
            bus_valid_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_wmask_q <= '0;
            bus_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            err_pulse_q <= 1'b0;
            err_flag_q  <= 1'b0;
        end else begin
            // Completion pulses last exactly one cycle (the RESP cycle).
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            err_pulse_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (i_req || d_req) begin
                        state_q     <= ST_BUSY;
                        gnt_data_q  <= grant_data_s;
                        last_data_q <= grant_data_s;
                        wait_q      <= '0;
                        bus_valid_q <= 1'b1;
                        if (grant_data_s) begin
                            bus_addr_q  <= d_addr;
                            bus_wmask_q <= d_wmask;
                            bus_wdata_q <= d_wdata;
                        end else begin
                            bus_addr_q  <= i_addr;
                            bus_wmask_q <= '0;
                            bus_wdata_q <= '0;
                        end
                    end else begin
                        state_q     <= ST_IDLE;
                        bus_valid_q <= 1'b0;
                    end
                end

                ST_BUSY: begin
                    if (bus_ready) begin
                        // Captured for writes too; requesters ignore it.
                        state_q     <= ST_RESP;
                        bus_valid_q <= 1'b0;
                        if (gnt_data_q) begin
                            d_rdata_q <= bus_rdata;
                            d_ack_q   <= 1'b1;
                        end else begin
                            i_rdata_q <= bus_rdata;
                            i_ack_q   <= 1'b1;
                        end
                    end else if (abort_s) begin
                        state_q     <= ST_RESP;
                        bus_valid_q <= 1'b0;
                        err_pulse_q <= 1'b1;
                        err_flag_q  <= 1'b1;
                        wait_q      <= wait_d;
                        if (gnt_data_q) begin
                            d_rdata_q <= '0;
                            d_ack_q   <= 1'b1;
                        end else begin
                            i_rdata_q <= '0;
                            i_ack_q   <= 1'b1;
                        end
                    end else begin
                        state_q     <= ST_BUSY;
                        wait_q      <= wait_d;
                    end
                end

                ST_RESP: begin
                    // Requests are deliberately not looked at here.
                    state_q     <= ST_IDLE;
                    bus_valid_q <= 1'b0;
                end

                default: begin
                    state_q     <= ST_IDLE;
                    bus_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign i_rdata   = i_rdata_q;
    assign i_ack     = i_ack_q;
    assign d_rdata   = d_rdata_q;
    assign d_ack     = d_ack_q;
    assign bus_valid = bus_valid_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wmask = bus_wmask_q;
    assign bus_wdata = bus_wdata_q;
    assign err_pulse = err_pulse_q;
    assign err_flag  = err_flag_q;

endmodule

// File: tb/tb_core_biu.sv
// -----------------------------------------------------------------------------
// tb_core_biu -- self-checking bench for core_biu (TIMEOUT = 4).
// Directed scenarios followed by randomized transactions, all checked against
// a transaction-level reference model kept in this file.
// -----------------------------------------------------------------------------
module tb_core_biu;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int SW    = DW / 8;
    localparam int TB_TO = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           i_req;
    logic [AW-1:0]  i_addr;
    logic [DW-1:0]  i_rdata;
    logic           i_ack;
    logic           d_req;
    logic [AW-1:0]  d_addr;
    logic [SW-1:0]  d_wmask;
    logic [DW-1:0]  d_wdata;
    logic [DW-1:0]  d_rdata;
    logic           d_ack;
    logic           bus_valid;
    logic [AW-1:0]  bus_addr;
    logic [SW-1:0]  bus_wmask;
    logic [DW-1:0]  bus_wdata;
    logic           bus_ready;
    logic [DW-1:0]  bus_rdata;
    logic           err_pulse;
    logic           err_flag;

    int checks = 0;
    int errors = 0;

    // Reference model state (transaction level).
    bit             last_data_m;
    bit             err_flag_m;
    logic [DW-1:0]  i_rdata_m;
    logic [DW-1:0]  d_rdata_m;

    core_biu #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TB_TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ack     (i_ack),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_wmask   (d_wmask),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .bus_valid (bus_valid),
        .bus_addr  (bus_addr),
        .bus_wmask (bus_wmask),
        .bus_wdata (bus_wdata),
        .bus_ready (bus_ready),
        .bus_rdata (bus_rdata),
        .err_pulse (err_pulse),
        .err_flag  (err_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        last_data_m = 1'b0;
        err_flag_m  = 1'b0;
        i_rdata_m   = '0;
        d_rdata_m   = '0;
    endtask

    task automatic scramble_requesters();
        i_req   = 1'($urandom_range(0, 1));
        i_addr  = $urandom;
        d_req   = 1'($urandom_range(0, 1));
        d_addr  = $urandom;
        d_wmask = 4'($urandom_range(0, 15));
        d_wdata = $urandom;
    endtask

    task automatic check_idle();
        chk("idle_bus_valid", bus_valid, 1'b0);
        chk("idle_i_ack",     i_ack,     1'b0);
        chk("idle_d_ack",     d_ack,     1'b0);
        chk("idle_err_pulse", err_pulse, 1'b0);
        chk("idle_err_flag",  err_flag,  err_flag_m);
        chk("idle_i_rdata",   i_rdata,   i_rdata_m);
        chk("idle_d_rdata",   d_rdata,   d_rdata_m);
    endtask

    // One full transaction from IDLE. ready_cyc is the 1-based BUSY cycle in
    // which bus_ready is raised (0 = never). If ready_cyc is 0 or beyond the
    // timeout, the transaction aborts in BUSY cycle TB_TO.
    task automatic do_txn(input bit ireq, input bit dreq,
                          input logic [AW-1:0] ia, input logic [AW-1:0] da,
                          input logic [SW-1:0] wm, input logic [DW-1:0] wd,
                          input int ready_cyc, input logic [DW-1:0] rd,
                          input bit scr);
        bit             gd;
        bit             aborted;
        bit             done;
        logic [AW-1:0]  ea;
        logic [SW-1:0]  ewm;
        logic [DW-1:0]  ewd;
        logic [DW-1:0]  erd;
        int             k;

        i_req     = ireq;
        i_addr    = ia;
        d_req     = dreq;
        d_addr    = da;
        d_wmask   = wm;
        d_wdata   = wd;
        bus_ready = 1'($urandom_range(0, 1));   // must be ignored in IDLE
        bus_rdata = $urandom;

        gd  = (ireq && dreq) ? !last_data_m : dreq;
        ea  = gd ? da : ia;
        ewm = gd ? wm : '0;
        ewd = gd ? wd : '0;

        step();   // grant edge
        last_data_m = gd;
        aborted = 1'b0;
        done    = 1'b0;
        k       = 1;
        while (!done) begin
            chk("busy_valid",     bus_valid, 1'b1);
            chk("busy_addr",      bus_addr,  ea);
            chk("busy_wmask",     bus_wmask, ewm);
            chk("busy_wdata",     bus_wdata, ewd);
            chk("busy_i_ack",     i_ack,     1'b0);
            chk("busy_d_ack",     d_ack,     1'b0);
            chk("busy_err_pulse", err_pulse, 1'b0);
            if (scr) scramble_requesters();
            bus_ready = (k == ready_cyc);
            bus_rdata = (k == ready_cyc) ? rd : $urandom;
            if (k == ready_cyc) begin
                done = 1'b1;
            end else if (k == TB_TO) begin
                done    = 1'b1;
                aborted = 1'b1;
            end
            k++;
            step();
        end

        // RESP cycle
        erd = aborted ? '0 : rd;
        if (gd) d_rdata_m = erd;
        else    i_rdata_m = erd;
        if (aborted) err_flag_m = 1'b1;
        bus_ready = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
        chk("resp_i_ack",     i_ack,     gd ? 1'b0 : 1'b1);
        chk("resp_d_ack",     d_ack,     gd ? 1'b1 : 1'b0);
        chk("resp_bus_valid", bus_valid, 1'b0);
        chk("resp_err_pulse", err_pulse, aborted);
        chk("resp_err_flag",  err_flag,  err_flag_m);
        chk("resp_i_rdata",   i_rdata,   i_rdata_m);
        chk("resp_d_rdata",   d_rdata,   d_rdata_m);
        if (scr) scramble_requesters();   // not sampled in RESP
        step();
        check_idle();
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        i_req     = 1'b0;
        i_addr    = '0;
        d_req     = 1'b0;
        d_addr    = '0;
        d_wmask   = '0;
        d_wdata   = '0;
        bus_ready = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
        model_reset();

        step();
        step();
        chk("rst_bus_addr",  bus_addr,  32'h0);
        chk("rst_bus_wmask", bus_wmask, 4'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        check_idle();
        rst = 1'b0;

        // Conflict after reset: data first, then instruction (requests held).
        do_txn(1'b1, 1'b1, 32'h0000_1000, 32'h0000_2000, 4'b1111, 32'hCAFE_0001, 1, 32'h1111_1111, 1'b0);
        do_txn(1'b1, 1'b1, 32'h0000_1000, 32'h0000_2000, 4'b1111, 32'hCAFE_0001, 2, 32'h2222_2222, 1'b0);

        // Single read, ready on first BUSY cycle.
        do_txn(1'b0, 1'b1, 32'h0, 32'h0000_0100, 4'b0000, 32'h0, 1, 32'hDEAD_BEEF, 1'b1);

        // Write with 3 wait states (ready exactly at the timeout boundary).
        do_txn(1'b0, 1'b1, 32'h0, 32'h0000_0200, 4'b0011, 32'h1234_5678, 4, 32'h0BAD_F00D, 1'b1);

        // Instruction fetch with one wait state.
        do_txn(1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'b0000, 32'h0, 2, 32'hA5A5_5A5A, 1'b1);

        // Timeout: bus_ready never comes.
        do_txn(1'b1, 1'b0, 32'h0000_0800, 32'h0, 4'b0000, 32'h0, 0, 32'h7777_7777, 1'b1);

        // Boundary again after an error: normal completion, flag stays set.
        do_txn(1'b0, 1'b1, 32'h0, 32'h0000_0300, 4'b0000, 32'h0, 4, 32'h3333_3333, 1'b1);

        // Ready one cycle too late: abort.
        do_txn(1'b0, 1'b1, 32'h0, 32'h0000_0304, 4'b1000, 32'h4444_4444, 5, 32'h5555_5555, 1'b1);

        // Reset during a wait state of a data transaction.
        i_req     = 1'b0;
        d_req     = 1'b1;
        d_addr    = 32'h0000_0500;
        d_wmask   = 4'b0000;
        bus_ready = 1'b0;
        step();
        chk("mid_busy_valid", bus_valid, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst   = 1'b0;
        d_req = 1'b0;
        model_reset();
        chk("mrst_bus_valid", bus_valid, 1'b0);
        chk("mrst_i_ack",     i_ack,     1'b0);
        chk("mrst_d_ack",     d_ack,     1'b0);
        chk("mrst_err_flag",  err_flag,  1'b0);
        chk("mrst_bus_addr",  bus_addr,  32'h0);
        step();
        check_idle();

        // Round-robin pointer restored by reset: conflict goes to data.
        do_txn(1'b1, 1'b1, 32'h0000_0600, 32'h0000_0700, 4'b0101, 32'h6666_6666, 1, 32'h8888_8888, 1'b0);

        // Randomized transactions with idle gaps.
        for (int n = 0; n < 60; n++) begin
            bit            ri;
            bit            rdq;
            int            gap;
            ri  = 1'($urandom_range(0, 1));
            rdq = 1'($urandom_range(0, 1));
            if (!ri && !rdq) rdq = 1'b1;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                i_req     = 1'b0;
                d_req     = 1'b0;
                bus_ready = 1'($urandom_range(0, 1));
                bus_rdata = $urandom;
                step();
                check_idle();
            end
            do_txn(ri, rdq, $urandom, $urandom, 4'($urandom_range(0, 15)), $urandom,
                   $urandom_range(0, 6), $urandom, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
